framebuffer_writer: RTL and testbench

//  Upstream producer for the VGA scan-out stage: accepts (x,y,color) pixel writes, buffers them, and

---
 rtl/framebuffer_writer_pkg.sv | 68 ++++++
 rtl/framebuffer_writer_fifo.sv | 51 +++++
 rtl/framebuffer_writer.sv | 192 +++++++++++++++++++
 tb/tb_framebuffer_writer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/framebuffer_writer_pkg.sv
// Shared types and helpers for the framebuffer writer.
// Optional feature macro: FB_CLEAR_EN (adds the back-buffer clear state).
package framebuffer_writer_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int FB_WORDS = 153600;
  localparam int ADDR_W   = 20;

  typedef logic [7:0]        VgaColor_t;
  typedef logic [ADDR_W-1:0] SramAddress_t;

  // One SRAM word holds two pixels; scan-out shows pixelOdd first for even x.
  typedef struct packed {
    VgaColor_t pixelEven;
    VgaColor_t pixelOdd;
  } Pixel_t;

  typedef struct packed {
    SramAddress_t address;
    Pixel_t       dout;
    logic         oe_n;
    logic         we_n;
    logic         den;
  } SramRequest_t;

  typedef struct packed {
    Pixel_t din;
  } SramResult_t;

  // Queued pixel write, address is resolved at issue time
  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    VgaColor_t  color;
  } PixWrite_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_MRG,
    ST_WR
`ifdef FB_CLEAR_EN
    , ST_CLR
`endif
  } FbState_t;

  // Word offset of a pixel inside one buffer (two pixels per word)
  function automatic logic [19:0] pix_offset(input logic [9:0] x, input logic [8:0] y);
    logic [19:0] lin;
    lin = 20'(y) * 20'(H_ACTIVE) + 20'(x);
    return lin >> 1;
  endfunction

  function automatic logic pix_in_range(input logic [9:0] x, input logic [8:0] y);
    return (x < 10'(H_ACTIVE)) && (y < 9'(V_ACTIVE));
  endfunction

  // Replace the half addressed by x[0]: odd x lands in pixelEven, even x in pixelOdd
  function automatic Pixel_t pix_merge(input Pixel_t w, input logic odd, input VgaColor_t c);
    Pixel_t m;
    m = w;
    if (odd) m.pixelEven = c;
    else     m.pixelOdd  = c;
    return m;
  endfunction

endpackage

// File: rtl/framebuffer_writer_fifo.sv
// Pixel-write FIFO: synchronous, power-of-two depth, push and pop may coincide.
// Unaffected by FB_CLEAR_EN.
module fb_write_fifo
  import framebuffer_writer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  logic      i_pop,
  input  PixWrite_t i_wdata,
  output PixWrite_t o_rdata,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = $clog2(DEPTH);

  PixWrite_t      r_mem [DEPTH];
  logic [AW-1:0]  r_wptr, r_rptr;
  logic [AW:0]    r_count;
  logic           w_push, w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr];

  // Storage, no reset needed: only entries covered by r_count are read
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= i_wdata;

  // Pointers wrap naturally; count holds when push and pop coincide
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end

endmodule

// File: rtl/framebuffer_writer.sv
// Framebuffer writer: queues pixel writes and performs read-modify-write into the
// back buffer during vertical blank, within a per-blank cycle budget; swaps
// front/back base addresses at the start of a blank once a frame is finished.
// Optional feature macro: FB_CLEAR_EN (clrReq/clrColor ports and CLR state).
module framebuffer_writer
  import framebuffer_writer_pkg::*;
#(
  parameter SramAddress_t BUF0_BASE     = 20'd0,
  parameter SramAddress_t BUF1_BASE     = 20'd153600,
  parameter int           FIFO_DEPTH    = 16,
  parameter int           VBLANK_BUDGET = 35000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         paintDone,
  input  logic         wrValid,
  output logic         wrReady,
  input  logic [9:0]   wrX,
  input  logic [8:0]   wrY,
  input  VgaColor_t    wrColor,
  input  logic         frameDone,
  output logic         swapPending,
  output logic         busOwner,
  input  SramResult_t  ramResult,
  output SramRequest_t ramRequest,
  output SramAddress_t displayBase
`ifdef FB_CLEAR_EN
  ,
  input  logic         clrReq,
  input  VgaColor_t    clrColor
`endif
);

  localparam int                CNT_W    = $clog2(VBLANK_BUDGET + 1);
  localparam logic [CNT_W-1:0]  BUDGET_C = CNT_W'(VBLANK_BUDGET);

  FbState_t         r_state, w_next;
  SramAddress_t     r_back, r_disp, r_addr;
  Pixel_t           r_din, r_dout;
  logic             r_pending, r_pd_q;
  logic [CNT_W-1:0] r_cnt;
  PixWrite_t        w_head, w_wdata;
  logic             w_full, w_empty, w_push, w_pop, w_window, w_swap, w_clr_busy;

  // Input side: out-of-range writes handshake but are never queued
  assign wrReady     = !rst && !w_full && !r_pending;
  assign w_push      = wrValid && wrReady && pix_in_range(wrX, wrY);
  assign w_wdata     = '{x: wrX, y: wrY, color: wrColor};
  assign swapPending = r_pending;
  assign displayBase = r_disp;
  assign w_window    = paintDone && (r_cnt < BUDGET_C);

  fb_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Blank budget counter: counts cycles since paintDone rose, saturates at the budget
  always_ff @(posedge clk or posedge rst)
    if (rst)                 r_cnt <= '0;
    else if (!paintDone)     r_cnt <= '0;
    else if (r_cnt < BUDGET_C) r_cnt <= r_cnt + CNT_W'(1);

`ifdef FB_CLEAR_EN
  localparam logic [17:0] CLR_LAST = 18'(FB_WORDS - 1);

  logic        r_clr_active;
  logic [17:0] r_clr_off;
  VgaColor_t   r_clr_color;

  assign w_clr_busy = r_clr_active;

  // Clear progress: a request (re)starts at offset 0, one word per in-window CLR cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_clr_active <= 1'b0;
      r_clr_off    <= '0;
      r_clr_color  <= '0;
    end else if (clrReq) begin
      r_clr_active <= 1'b1;
      r_clr_off    <= '0;
      r_clr_color  <= clrColor;
    end else if (r_state == ST_CLR && w_window) begin
      if (r_clr_off == CLR_LAST) begin
        r_clr_active <= 1'b0;
        r_clr_off    <= '0;
      end else begin
        r_clr_off <= r_clr_off + 18'd1;
      end
    end
`else
  assign w_clr_busy = 1'b0;
`endif

  // Swap only at the very start of a blank with nothing queued or in flight
  assign w_swap = r_pending && paintDone && !r_pd_q && w_empty &&
                  (r_state == ST_IDLE) && !w_clr_busy;

  // Front/back base registers and swap request
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pd_q    <= 1'b0;
      r_pending <= 1'b0;
      r_disp    <= BUF0_BASE;
      r_back    <= BUF1_BASE;
    end else begin
      r_pd_q <= paintDone;
      if (w_swap) begin
        r_disp    <= r_back;
        r_back    <= r_disp;
        r_pending <= 1'b0;
      end else if (frameDone) begin
        r_pending <= 1'b1;
      end
    end

  // FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;

  // Next state and SRAM drive; ops always run to WR once started
  always_comb begin
    w_next             = r_state;
    w_pop              = 1'b0;
    busOwner           = 1'b0;
    ramRequest.address = r_addr;
    ramRequest.dout    = r_dout;
    ramRequest.oe_n    = 1'b1;
    ramRequest.we_n    = 1'b1;
    ramRequest.den     = 1'b0;
    case (r_state)
      ST_IDLE: begin
`ifdef FB_CLEAR_EN
        if (r_clr_active) w_next = ST_CLR;
        else
`endif
        if (w_window && !w_empty) w_next = ST_RD;
      end
      ST_RD: begin
        busOwner        = 1'b1;
        ramRequest.oe_n = 1'b0;
        w_next          = ST_MRG;
      end
      ST_MRG: begin
        busOwner = 1'b1;
        w_pop    = 1'b1;
        w_next   = ST_WR;
      end
      ST_WR: begin
        busOwner        = 1'b1;
        ramRequest.we_n = 1'b0;
        ramRequest.den  = 1'b1;
        w_next          = ST_IDLE;
      end
`ifdef FB_CLEAR_EN
      ST_CLR: begin
        // Parked here across blanks; only drives the bus inside the window
        busOwner           = w_window;
        ramRequest.address = r_back + SramAddress_t'(r_clr_off);
        ramRequest.dout    = '{pixelEven: r_clr_color, pixelOdd: r_clr_color};
        ramRequest.we_n    = !w_window;
        ramRequest.den     = w_window;
        if (w_window && r_clr_off == CLR_LAST && !clrReq) w_next = ST_IDLE;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  // Op datapath: address at issue, read data at end of RD, merged word in MRG
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_addr <= '0;
      r_din  <= '0;
      r_dout <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_next == ST_RD) r_addr <= r_back + pix_offset(w_head.x, w_head.y);
        ST_RD:   r_din  <= ramResult.din;
        ST_MRG:  r_dout <= pix_merge(r_din, w_head.x[0], w_head.color);
        default: ;
      endcase
    end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer (budget shrunk to 10 cycles per blank).
// Builds with or without FB_CLEAR_EN; clear inputs are held idle.
module tb_framebuffer_writer;
  import framebuffer_writer_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         paintDone = 1'b0, wrValid = 1'b0, frameDone = 1'b0;
  logic [9:0]   wrX = '0;
  logic [8:0]   wrY = '0;
  VgaColor_t    wrColor = '0;
  logic         wrReady, swapPending, busOwner;
  SramResult_t  ramResult;
  SramRequest_t ramRequest;
  SramAddress_t displayBase;
`ifdef FB_CLEAR_EN
  logic         clrReq = 1'b0;
  VgaColor_t    clrColor = '0;
`endif

  int n_tot = 0, n_bad = 0;

  always #5 clk = ~clk;

  framebuffer_writer #(.VBLANK_BUDGET(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .paintDone   (paintDone),
    .wrValid     (wrValid),
    .wrReady     (wrReady),
    .wrX         (wrX),
    .wrY         (wrY),
    .wrColor     (wrColor),
    .frameDone   (frameDone),
    .swapPending (swapPending),
    .busOwner    (busOwner),
    .ramResult   (ramResult),
    .ramRequest  (ramRequest),
    .displayBase (displayBase)
`ifdef FB_CLEAR_EN
    ,
    .clrReq      (clrReq),
    .clrColor    (clrColor)
`endif
  );

  // Bus log sampled on the falling edge; pd_idx = cycles since paintDone rose
  int           wr_n = 0, rd_n = 0, pd_idx = 0, own_err = 0;
  SramAddress_t wr_addr [256];
  SramAddress_t rd_addr [256];
  Pixel_t       wr_dout [256];
  int           wr_idx  [256];

  always @(negedge clk) begin
    if (!ramRequest.oe_n && rd_n < 256) begin
      rd_addr[rd_n] = ramRequest.address;
      rd_n++;
    end
    if (!ramRequest.we_n && wr_n < 256) begin
      wr_addr[wr_n] = ramRequest.address;
      wr_dout[wr_n] = ramRequest.dout;
      wr_idx[wr_n]  = pd_idx;
      wr_n++;
    end
    if ((!ramRequest.oe_n || !ramRequest.we_n) && !busOwner) own_err++;
    if (paintDone) pd_idx++;
    else           pd_idx = 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int x, input int y, input logic [7:0] c);
    int t;
    t = 0;
    wrX = 10'(x); wrY = 9'(y); wrColor = c; wrValid = 1'b1;
    while (!wrReady && t < 200) begin tick(); t++; end
    if (t >= 200) chk("push_timeout", 32'(t), 0);
    tick();
    wrValid = 1'b0;
  endtask

  int wb, rb, t;

  initial begin
    ramResult.din = 16'h1234;

    // Reset state
    tick(2);
    chk("rst_oe_n",  ramRequest.oe_n, 1);
    chk("rst_we_n",  ramRequest.we_n, 1);
    chk("rst_den",   ramRequest.den, 0);
    chk("rst_addr",  ramRequest.address, 0);
    chk("rst_dout",  ramRequest.dout, 0);
    chk("rst_owner", busOwner, 0);
    chk("rst_swap",  swapPending, 0);
    chk("rst_ready", wrReady, 0);
    chk("rst_disp",  displayBase, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", wrReady, 1);
    tick(2);

    // Writes outside blank stay queued; out-of-range entries dropped
    wb = wr_n; rb = rd_n;
    push(3, 0, 8'hA5);
    push(640, 0, 8'h11);
    push(4, 1, 8'h5C);
    push(0, 480, 8'h22);
    push(639, 479, 8'h77);
    tick(5);
    chk("no_sram_outside_blank", 32'(wr_n - wb + rd_n - rb), 0);
    paintDone = 1'b1;
    tick(20);
    paintDone = 1'b0;
    tick(2);
    chk("blank1_writes", 32'(wr_n - wb), 3);
    chk("rd0_addr",  rd_addr[rb], 153601);
    chk("wr0_addr",  wr_addr[wb], 153601);
    chk("wr0_dout",  wr_dout[wb], 16'hA534);
    chk("wr1_addr",  wr_addr[wb+1], 153922);
    chk("wr1_dout",  wr_dout[wb+1], 16'h125C);
    chk("wr2_addr",  wr_addr[wb+2], 307199);
    chk("wr2_dout",  wr_dout[wb+2], 16'h7734);

    // Fill FIFO, 17th write held until the first pop
    wb = wr_n;
    for (int i = 0; i < 16; i++) push(i, 2, 8'(8'h40 + i));
    chk("full_ready", wrReady, 0);
    wrX = 10'd16; wrY = 9'd2; wrColor = 8'h50; wrValid = 1'b1;
    tick(3);
    chk("held_ready", wrReady, 0);
    paintDone = 1'b1;
    t = 0;
    while (!wrReady && t < 50) begin tick(); t++; end
    chk("ready_timeout", 32'(t < 50), 1);
    tick();
    wrValid = 1'b0;
    chk("accept_after_pop", 32'(wr_n - wb), 1);
    tick(16);
    paintDone = 1'b0;
    tick(2);
    chk("budget_writes", 32'(wr_n - wb), 3);
    chk("fill_wr0_addr", wr_addr[wb], 154240);
    chk("fill_wr0_dout", wr_dout[wb], 16'h1240);
    chk("first_wr_idx",  32'(wr_idx[wb]), 3);
    chk("inflight_idx",  32'(wr_idx[wb+2]), 11);

    // Reset in the middle of RD
    paintDone = 1'b1;
    t = 0;
    while (ramRequest.oe_n && t < 20) begin tick(); t++; end
    chk("rd_seen", 32'(t < 20), 1);
    rst = 1'b1;
    #1;
    chk("mid_oe_n",  ramRequest.oe_n, 1);
    chk("mid_we_n",  ramRequest.we_n, 1);
    chk("mid_owner", busOwner, 0);
    tick();
    chk("mid_disp",  displayBase, 0);
    rst = 1'b0;
    rb = rd_n;
    tick(10);
    chk("fifo_empty_after_rst", 32'(rd_n - rb), 0);
    chk("ready_after_mid_rst", wrReady, 1);
    paintDone = 1'b0;
    tick(2);

    // Swap waits for queued writes, then applies on the following blank
    wb = wr_n;
    push(10, 10, 8'h31);
    push(11, 10, 8'h42);
    frameDone = 1'b1; tick(); frameDone = 1'b0;
    chk("swap_pending", swapPending, 1);
    chk("swap_blocks_in", wrReady, 0);
    frameDone = 1'b1; tick(); frameDone = 1'b0;
    paintDone = 1'b1;
    tick(20);
    chk("no_swap_busy", displayBase, 0);
    paintDone = 1'b0;
    tick(2);
    chk("swap_writes", 32'(wr_n - wb), 2);
    chk("swap_wr0_addr", wr_addr[wb], 156805);
    chk("swap_wr0_dout", wr_dout[wb], 16'h1231);
    chk("swap_wr1_dout", wr_dout[wb+1], 16'h4234);
    chk("still_pending", swapPending, 1);
    paintDone = 1'b1;
    tick(2);
    chk("swap_disp",  displayBase, 153600);
    chk("swap_clear", swapPending, 0);
    chk("swap_ready", wrReady, 1);
    wb = wr_n;
    push(0, 0, 8'h99);
    tick(10);
    paintDone = 1'b0;
    tick(2);
    chk("newback_writes", 32'(wr_n - wb), 1);
    chk("newback_addr", wr_addr[wb], 0);
    chk("newback_dout", wr_dout[wb], 16'h1299);

    chk("bus_owner_during_access", 32'(own_err), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
